// File: rtl/spi_master_tx.sv
// Byte-stream SPI mode-0 transmitter: one CS frame per i_last-terminated run of bytes.
// Latency: CS falls 1 cycle after accept; first SCK rise CS_SETUP+CLK_DIV cycles later.
// Backpressure: o_ready only in IDLE/LOAD; with no byte in LOAD, SCK parks low and CS stays asserted.
module spi_master_tx #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    output logic       o_spi_cs,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        LOAD,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    state_t     state_q;
    logic [7:0] shift_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic       last_q;
    logic       accept;

    assign accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= 8'd0;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            last_q     <= 1'b0;
            o_ready    <= 1'b0;
            o_spi_clk  <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_spi_cs   <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q    <= i_data;
                        last_q     <= i_last;
                        o_spi_mosi <= i_data[7];
                        o_spi_cs   <= 1'b0;
                        o_spi_clk  <= 1'b0;
                        o_ready    <= 1'b0;
                        o_busy     <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= SETUP;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= 8'd0;
                        if (!o_spi_clk) begin
                            o_spi_clk <= 1'b1;
                        end else begin
                            // Falling edge: next bit launches on the same cycle SCK drops.
                            o_spi_clk  <= 1'b0;
                            shift_q    <= {shift_q[6:0], shift_q[7]};
                            o_spi_mosi <= shift_q[6];
                            bit_q      <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                if (last_q) begin
                                    state_q <= HOLD;
                                end else begin
                                    o_ready <= 1'b1;
                                    state_q <= LOAD;
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shift_q    <= i_data;
                        last_q     <= i_last;
                        o_spi_mosi <= i_data[7];
                        o_ready    <= 1'b0;
                        cnt_q      <= 8'd0;
                        state_q    <= SHIFT;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q      <= 8'd0;
                        o_spi_cs   <= 1'b1;
                        o_spi_mosi <= 1'b0;
                        o_done     <= 1'b1;
                        state_q    <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= 8'd0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default instance plus an all-ones-parameter instance, each watched
// by an SPI receiver model that rebuilds bytes and frame timing from the pins alone.
module tb_spi_master_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] valid, last, ready, sck, mosi, cs, busy, done;
    logic [7:0] data [2];

    spi_master_tx u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]), .i_last(last[0]),
        .o_ready(ready[0]), .o_spi_clk(sck[0]), .o_spi_mosi(mosi[0]), .o_spi_cs(cs[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    spi_master_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]), .i_last(last[1]),
        .o_ready(ready[1]), .o_spi_clk(sck[1]), .o_spi_mosi(mosi[1]), .o_spi_cs(cs[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    int checks = 0;
    int errors = 0;

    // Receiver-side observations, one slot per instance.
    int         low_run[2]     = '{0, 0};
    int         high_run[2]    = '{0, 0};
    int         last_low[2]    = '{0, 0};
    int         last_gap[2]    = '{0, 0};
    int         frame_edges[2] = '{0, 0};
    int         last_edges[2]  = '{0, 0};
    int         frames[2]      = '{0, 0};
    int         edges_total[2] = '{0, 0};
    int         nbits[2]       = '{0, 0};
    int         done_cnt[2]    = '{0, 0};
    int         proto_err[2]   = '{0, 0};
    int         rx_n[2]        = '{0, 0};
    int         exp_n[2]       = '{0, 0};
    logic [7:0] acc[2];
    logic [7:0] rx_log[2][256];
    logic [7:0] exp_log[2][256];
    logic       prev_cs[2]     = '{1'b1, 1'b1};
    logic       prev_sck[2]    = '{1'b0, 1'b0};
    logic       prev_mosi[2]   = '{1'b0, 1'b0};
    logic [7:0] frame_buf[8];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs[k] === 1'b0) begin
                if (prev_cs[k]) begin
                    last_gap[k]    = high_run[k];
                    low_run[k]     = 0;
                    frame_edges[k] = 0;
                    nbits[k]       = 0;
                end
                low_run[k]++;
            end else begin
                if (!prev_cs[k]) begin
                    last_low[k]   = low_run[k];
                    last_edges[k] = frame_edges[k];
                    frames[k]++;
                    high_run[k]   = 0;
                end
                high_run[k]++;
                if (mosi[k] !== 1'b0 || sck[k] !== 1'b0) proto_err[k]++;
            end
            if (sck[k] && !prev_sck[k]) begin
                edges_total[k]++;
                if (cs[k]) proto_err[k]++;
                else begin
                    frame_edges[k]++;
                    acc[k] = {acc[k][6:0], mosi[k]};
                    nbits[k]++;
                    if (nbits[k] == 8) begin
                        rx_log[k][rx_n[k] % 256] = acc[k];
                        rx_n[k]++;
                        nbits[k] = 0;
                    end
                end
            end
            if (sck[k] && prev_sck[k] && mosi[k] !== prev_mosi[k]) proto_err[k]++;
            if (done[k]) begin
                done_cnt[k]++;
                if (!(cs[k] && !prev_cs[k])) proto_err[k]++;
            end
            prev_cs[k]   = cs[k];
            prev_sck[k]  = sck[k];
            prev_mosi[k] = mosi[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input int k, input logic [7:0] d, input logic l);
        int t = 0;
        valid[k] = 1'b1;
        data[k]  = d;
        last[k]  = l;
        while (ready[k] !== 1'b1 && t < 5000) begin
            tick();
            t++;
        end
        chk("accept_wait", int'(t < 5000), 1);
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
        last[k]  = 1'($urandom);
        tick();
    endtask

    task automatic wait_frame_end(input int k, input int f0);
        int t = 0;
        while (frames[k] == f0 && t < 5000) begin
            tick();
            t++;
        end
        chk("frame_end_wait", int'(t < 5000), 1);
    endtask

    task automatic wait_ready(input int k);
        int t = 0;
        while (ready[k] !== 1'b1 && t < 5000) begin
            tick();
            t++;
        end
        chk("ready_wait", int'(t < 5000), 1);
    endtask

    // Sends frame_buf[0..n-1] as one frame and checks timing against the pin-level rules.
    task automatic run_frame(input int k, input int n, input int div, input int s, input int h,
                             input int g, input bit check_gap);
        int f0 = frames[k];
        int d0 = done_cnt[k];
        int nr = 0;
        for (int i = 0; i < n; i++) begin
            exp_log[k][exp_n[k]] = frame_buf[i];
            exp_n[k]++;
            send_byte(k, frame_buf[i], 1'(i == n - 1));
        end
        wait_frame_end(k, f0);
        chk("cs_low_cycles", last_low[k], s + 16 * div * n + (n - 1) + h);
        chk("sck_rising_edges", last_edges[k], 8 * n);
        chk("done_on_cs_rise", int'(done[k]), 1);
        while (ready[k] !== 1'b1 && nr < 1000) begin
            tick();
            nr++;
        end
        chk("ready_after_gap", nr, g);
        chk("done_pulses", done_cnt[k] - d0, 1);
        chk("busy_in_idle", int'(busy[k]), 0);
        if (check_gap) chk("cs_high_gap", last_gap[k], g + 1);
    endtask

    initial begin
        int f0, d0, e0, bad, n, t;
        logic [7:0] b1, b2;
        rst_n = 1'b0;
        valid = 2'b00;
        last  = 2'b00;
        data  = '{8'd0, 8'd0};
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_cs", int'(cs[k]), 1);
            chk("rst_sck", int'(sck[k]), 0);
            chk("rst_mosi", int'(mosi[k]), 0);
            chk("rst_ready", int'(ready[k]), 0);
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_done", int'(done[k]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_first_edge_0", int'(ready[0]), 1);
        chk("ready_first_edge_1", int'(ready[1]), 1);
        tick();

        // Single 0xA5 frame with default timing.
        frame_buf[0] = 8'hA5;
        run_frame(0, 1, 2, 2, 2, 4, 1'b0);
        chk("a5_byte", int'(rx_log[0][(rx_n[0] - 1) % 256]), 8'hA5);

        // Five-byte frame, presented back to back.
        frame_buf[0] = 8'h2A; frame_buf[1] = 8'h00; frame_buf[2] = 8'h00;
        frame_buf[3] = 8'h01; frame_buf[4] = 8'h3F;
        run_frame(0, 5, 2, 2, 2, 4, 1'b1);

        // Stall in LOAD for 50 cycles between two bytes.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        f0 = frames[0];
        exp_log[0][exp_n[0]] = b1; exp_n[0]++;
        exp_log[0][exp_n[0]] = b2; exp_n[0]++;
        send_byte(0, b1, 1'b0);
        wait_ready(0);
        e0  = edges_total[0];
        bad = 0;
        repeat (50) begin
            tick();
            if (sck[0] !== 1'b0 || cs[0] !== 1'b0) bad++;
        end
        chk("stall_quiet", bad, 0);
        chk("stall_no_edges", edges_total[0] - e0, 0);
        send_byte(0, b2, 1'b1);
        wait_frame_end(0, f0);
        chk("stall_frame_edges", last_edges[0], 16);
        wait_ready(0);

        // Asynchronous reset mid-byte.
        d0 = done_cnt[0];
        send_byte(0, 8'($urandom), 1'b0);
        t = 0;
        while (frame_edges[0] < 3 && t < 5000) begin
            tick();
            t++;
        end
        chk("reset_point_wait", int'(t < 5000), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_cs", int'(cs[0]), 1);
        chk("abort_sck", int'(sck[0]), 0);
        chk("abort_mosi", int'(mosi[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_ready", int'(ready[0]), 0);
        repeat (3) tick();
        chk("abort_no_done_pulse", done_cnt[0] - d0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_abort", int'(ready[0]), 1);
        tick();
        for (int i = 0; i < 3; i++) frame_buf[i] = 8'($urandom);
        run_frame(0, 3, 2, 2, 2, 4, 1'b0);

        // Random frames on the default instance.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
            run_frame(0, n, 2, 2, 2, 4, 1'b1);
        end

        // Minimum-timing instance: back-to-back frames.
        for (int r = 0; r < 6; r++) begin
            n = (r < 4) ? 1 : $urandom_range(2, 3);
            for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
            run_frame(1, n, 1, 1, 1, 1, r > 0);
        end

        for (int k = 0; k < 2; k++) begin
            chk("rx_byte_count", rx_n[k], exp_n[k]);
            for (int i = 0; i < exp_n[k] && i < rx_n[k]; i++)
                chk("rx_byte", int'(rx_log[k][i]), int'(exp_log[k][i]));
            chk("protocol_errors", proto_err[k], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
